// File: rtl/mem_arbiter_pkg.sv
// Shared types for the LC-3b I-cache/D-cache physical-memory arbiter.
package mem_arbiter_pkg;

    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_RD,
        D_WR
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

    function automatic arb_owner_t owner_of(input arb_state_t s);
        return (s == I_BUSY) ? OWN_I : OWN_D;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Grant selection for the memory arbiter. Fixed D-cache priority by default;
// defining ARB_RR_EN alternates between caches when both request.
module mem_arbiter_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       icache_read,
    input  logic       dcache_read,
    input  logic       dcache_write,
    input  arb_owner_t last_grant,
    output arb_state_t next_state,
    output logic       grant_valid
);

    logic dcache_any;
    assign dcache_any = dcache_read | dcache_write;

`ifndef ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = (last_grant == OWN_D);
`endif

    always_comb begin
        next_state  = IDLE;
        grant_valid = icache_read | dcache_any;
        // Writeback always beats fill inside the D-cache side.
        if (dcache_write) begin
            next_state = D_WR;
        end else if (dcache_read) begin
            next_state = D_RD;
        end
        if (icache_read) begin
`ifdef ARB_RR_EN
            if (!dcache_any || last_grant == OWN_D) begin
                next_state = I_BUSY;
            end
`else
            if (!dcache_any) begin
                next_state = I_BUSY;
            end
`endif
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one physical-memory port between I-cache and D-cache, one line
// transaction at a time. Optional round-robin policy via ARB_RR_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t        state_q, state_d, pick_state;
    arb_owner_t        last_grant_q, last_grant_d;
    logic              pick_valid;
    logic [ADDR_W-1:0] addr_q, addr_d, granted_addr;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    mem_arbiter_arb_pick u_pick (
        .icache_read  (icache_read),
        .dcache_read  (dcache_read),
        .dcache_write (dcache_write),
        .last_grant   (last_grant_q),
        .next_state   (pick_state),
        .grant_valid  (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= OWN_I;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        granted_addr = (pick_state == I_BUSY) ? icache_address : dcache_address;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        icache_resp  = 1'b0;
        dcache_resp  = 1'b0;
        case (state_q)
            IDLE: begin
                // A stray pmem_resp here is ignored: only busy states complete.
                if (pick_valid) begin
                    state_d      = pick_state;
                    last_grant_d = owner_of(pick_state);
                    addr_d       = {granted_addr[ADDR_W-1:4], 4'h0};
                    if (pick_state == D_WR) begin
                        wdata_d = dcache_wdata;
                    end
                end
            end
            I_BUSY: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    icache_resp = 1'b1;
                    state_d     = IDLE;
                end
            end
            D_RD: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    dcache_resp = 1'b1;
                    state_d     = IDLE;
                end
            end
            D_WR: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    dcache_resp = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign icache_rdata = pmem_rdata;
    assign dcache_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter; honours ARB_RR_EN for the expected policy.
module tb_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              icache_read;
    logic [ADDR_W-1:0] icache_address;
    logic [LINE_W-1:0] icache_rdata;
    logic              icache_resp;
    logic              dcache_read;
    logic              dcache_write;
    logic [ADDR_W-1:0] dcache_address;
    logic [LINE_W-1:0] dcache_wdata;
    logic [LINE_W-1:0] dcache_rdata;
    logic              dcache_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        int                due;
    } txn_t;

    typedef struct {
        logic              to_i;
        logic [LINE_W-1:0] rdata;
        int                due;
    } rsp_t;

    txn_t exp_txn[$];
    rsp_t exp_rsp[$];

    // Reference model state: owner codes 1=I read, 2=D read, 3=D write.
    bit busy         = 1'b0;
    bit just_granted = 1'b0;
    bit last_i       = 1'b1;
    int own          = 0;
    int retire       = 0;
    int cnt          = 0;

    function automatic logic [LINE_W-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string name, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic step(input bit allow_new);
        bit                pick_i;
        bit                any_d;
        txn_t              t;
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = rnd128();
        if (!rst_n) rst_n = 1'b1;

        // Requesters: retire completed request, then raise/perturb/drop.
        case (retire)
            1: icache_read  = 1'b0;
            2: dcache_read  = 1'b0;
            3: dcache_write = 1'b0;
            default: ;
        endcase
        retire = 0;
        if (allow_new) begin
            if (!icache_read && !(busy && own == 1) && $urandom_range(0, 3) == 0) begin
                icache_read    = 1'b1;
                icache_address = 16'($urandom());
            end
            if (!dcache_read && !(busy && own == 2) && $urandom_range(0, 3) == 0) begin
                dcache_read    = 1'b1;
                dcache_address = 16'($urandom());
            end
            if (!dcache_write && !(busy && own == 3) && $urandom_range(0, 3) == 0) begin
                dcache_write   = 1'b1;
                dcache_address = 16'($urandom());
                dcache_wdata   = rnd128();
            end
        end
        if ($urandom_range(0, 2) == 0) icache_address = 16'($urandom());
        if ($urandom_range(0, 2) == 0) dcache_address = 16'($urandom());
        if ($urandom_range(0, 2) == 0) dcache_wdata   = rnd128();
        if (busy && $urandom_range(0, 15) == 0) begin
            case (own)
                1: icache_read  = 1'b0;
                2: dcache_read  = 1'b0;
                3: dcache_write = 1'b0;
                default: ;
            endcase
        end

        // Memory + arbitration reference.
        if (busy) begin
            if (!just_granted && cnt >= 2 && $urandom_range(0, 23) == 0) begin
                rst_n  = 1'b0;
                busy   = 1'b0;
                last_i = 1'b1;
            end else begin
                cnt--;
                if (cnt == 0) begin
                    pmem_resp = 1'b1;
                    exp_rsp.push_back('{own == 1, pmem_rdata, cyc});
                    busy   = 1'b0;
                    retire = own;
                end
            end
            just_granted = 1'b0;
        end else begin
            if ($urandom_range(0, 7) == 0) pmem_resp = 1'b1;
            if (icache_read || dcache_read || dcache_write) begin
                any_d = dcache_read || dcache_write;
`ifdef ARB_RR_EN
                pick_i = icache_read && (!any_d || !last_i);
`else
                pick_i = icache_read && !any_d;
`endif
                t.wdata = '0;
                if (pick_i) begin
                    own = 1; t.wr = 1'b0; t.addr = icache_address;
                end else if (dcache_write) begin
                    own = 3; t.wr = 1'b1; t.addr = dcache_address; t.wdata = dcache_wdata;
                end else begin
                    own = 2; t.wr = 1'b0; t.addr = dcache_address;
                end
                t.addr = t.addr & 16'hFFF0;
                t.due  = cyc + 1;
                exp_txn.push_back(t);
                last_i       = pick_i;
                busy         = 1'b1;
                cnt          = $urandom_range(1, 4);
                just_granted = 1'b1;
            end
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    initial begin
        bit   prev_s = 1'b0;
        bit   s;
        bit   rise;
        txn_t e;
        txn_t cur;
        rsp_t r;
        cur = '{1'b0, '0, '0, 0};
        forever begin
            @(negedge clk);
            #2;
            s    = pmem_read | pmem_write;
            rise = s && !prev_s;
            if (!rst_n) chk("reset_strobes", {pmem_read, pmem_write}, 2'b00);
            if (exp_txn.size() > 0 && exp_txn[0].due == cyc) begin
                e = exp_txn.pop_front();
                chk("grant_start", rise, 1'b1);
                chk("grant_kind", {pmem_read, pmem_write}, e.wr ? 2'b01 : 2'b10);
                chk("grant_addr", pmem_address, e.addr);
                if (e.wr) chk("grant_wdata", pmem_wdata, e.wdata);
                cur = e;
            end else begin
                chk("spurious_start", rise, 1'b0);
                if (s) begin
                    chk("hold_kind", {pmem_read, pmem_write}, cur.wr ? 2'b01 : 2'b10);
                    chk("hold_addr", pmem_address, cur.addr);
                    if (cur.wr) chk("hold_wdata", pmem_wdata, cur.wdata);
                end
            end
            if (exp_rsp.size() > 0 && exp_rsp[0].due == cyc) begin
                r = exp_rsp.pop_front();
                chk("icache_resp", icache_resp, r.to_i);
                chk("dcache_resp", dcache_resp, !r.to_i);
                if (r.to_i) chk("icache_rdata", icache_rdata, r.rdata);
                else        chk("dcache_rdata", dcache_rdata, r.rdata);
            end else begin
                chk("idle_resp", {icache_resp, dcache_resp}, 2'b00);
            end
            prev_s = s;
        end
    end

    initial begin
        int k;
        rst_n          = 1'b0;
        icache_read    = 1'b1;
        icache_address = 16'h1234;
        dcache_read    = 1'b0;
        dcache_write   = 1'b0;
        dcache_address = '0;
        dcache_wdata   = '0;
        pmem_resp      = 1'b0;
        pmem_rdata     = '0;
        repeat (2) @(negedge clk);
        #2;
        chk("reset_addr", pmem_address, '0);
        chk("reset_wdata", pmem_wdata, '0);
        for (int i = 0; i < 4000; i++) step(1'b1);
        k = 0;
        while ((busy || icache_read || dcache_read || dcache_write) && k < 200) begin
            step(1'b0);
            k++;
        end
        chk("drain_in_budget", k < 200, 1'b1);
        repeat (3) step(1'b0);
        #3;
        chk("txn_queue_empty", exp_txn.size(), 0);
        chk("rsp_queue_empty", exp_rsp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single physical-memory port between the I-cache (fetch stage) and the D-cache (MEM stage) of the 5-stage LC-3b pipeline.
- Latches one requester's line transaction and drives it to memory until memory responds.
- Routes the response back to that requester only.
- Default policy is fixed D-cache priority, so a pending load/store is never starved behind back-to-back fetch misses.

Parameters:
- ADDR_W, 16, byte address width (lc3b_word).
- LINE_W, 128, cache line width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- icache_read  in  1  I-cache line read request; held high until icache_resp.
- icache_address  in  ADDR_W  I-cache line address.
- icache_rdata  out  LINE_W  line returned to I-cache.
- icache_resp  out  1  one-cycle completion pulse to I-cache.
- dcache_read  in  1  D-cache line read (fill) request; held until dcache_resp.
- dcache_write  in  1  D-cache line write (writeback) request; held until dcache_resp.
- dcache_address  in  ADDR_W  D-cache line address.
- dcache_wdata  in  LINE_W  writeback line.
- dcache_rdata  out  LINE_W  line returned to D-cache.
- dcache_resp  out  1  one-cycle completion pulse to D-cache.
- pmem_read  out  1  memory read strobe.
- pmem_write  out  1  memory write strobe.
- pmem_address  out  ADDR_W  memory line address (low 4 bits forced 0).
- pmem_wdata  out  LINE_W  memory write data.
- pmem_rdata  in  LINE_W  memory read data.
- pmem_resp  in  1  memory completion, one cycle.

Behaviour:
- Reset values (asynchronous on rst_n low):
  - state=IDLE.
  - pmem_read, pmem_write, icache_resp and dcache_resp are 0.
  - Latched address and wdata registers are 0.
  - last_grant=I.
- State machine states: IDLE, I_BUSY, D_RD, D_WR.
- IDLE transitions:
  - dcache_write → D_WR.
  - else dcache_read → D_RD.
  - else icache_read → I_BUSY.
  - else stay.
  - D-cache wins any simultaneous request.
  - On the transition edge, latch the address with [3:0] cleared, and latch dcache_wdata for D_WR.
- Busy states:
  - pmem_read=1 in I_BUSY and D_RD; pmem_write=1 in D_WR.
  - pmem_address and pmem_wdata are driven from the latched registers only. Requester address changes mid-transaction are ignored.
- Completion:
  - When pmem_resp=1 in a busy state, the owner's resp=1 in the same cycle (combinational) and the owner's rdata=pmem_rdata.
  - Next state is IDLE.
  - The non-owner's resp stays 0.
- rdata outputs: icache_rdata and dcache_rdata always pass pmem_rdata through. They are valid only while the matching resp is high.
- Latency:
  - Request seen in IDLE at edge N → strobe high from cycle N+1.
  - Total latency is memory latency +1 cycle.
  - At least one IDLE cycle follows every completion, so strobes deassert for ≥1 cycle between transactions.
- Protocol boundaries:
  - pmem_resp in IDLE is ignored.
  - dcache_read and dcache_write both high: the write is serviced; the read is re-evaluated after completion if still held.
  - A requester that drops its request mid-transaction does not abort it. The transaction completes and the resp pulse is still issued.
- Reset mid-transaction: the FSM returns to IDLE and strobes drop immediately. The in-flight transaction is lost and no resp is issued.
- last_grant updates on every IDLE→busy transition.

Optional Feature:
- ARB_RR_EN defined:
  - When both caches request in IDLE, grant the side opposite last_grant.
  - A single requester is always granted.
  - Read/write precedence within the D-cache is unchanged.
- ARB_RR_EN undefined: fixed D-cache priority as above; last_grant is still maintained but unused.

Decomposition:
- lc3b_types additions:
  - lc3b_line (logic [127:0]).
  - arb_state_t enum {IDLE, I_BUSY, D_RD, D_WR}.
  - arb_owner_t enum {OWN_I, OWN_D}.
- Sub-module arb_pick (combinational):
  - Inputs: icache_read, dcache_read, dcache_write, last_grant.
  - Outputs: next busy state and a grant-valid flag.
  - Isolates the ARB_RR_EN policy from the FSM and datapath registers.

Test Plan:
- Reset with icache_read=1 held, then release rst_n → pmem_read rises one cycle after the first edge, pmem_address=icache_address&0xFFF0. pmem_resp after 3 cycles → icache_resp pulses 1 cycle and icache_rdata=pmem_rdata; dcache_resp stays 0.
- icache_read and dcache_read both asserted in the same IDLE cycle, address 0x1234 and 0x8000 → pmem_address=0x8000 first; after its resp, ≥1 idle cycle, then 0x1230.
- dcache_write with wdata=0xDEADBEEF…; change dcache_address and dcache_wdata mid-transaction → pmem_address and pmem_wdata keep the latched values until pmem_resp.
- pmem_resp pulsed while IDLE → no resp pulse, state stays IDLE.
- rst_n low during D_RD → pmem_read drops asynchronously; no dcache_resp; after release, a held request is re-granted from IDLE.
- With ARB_RR_EN: both caches request continuously for 4 transactions → grant order D, I, D, I (last_grant=I after reset). Without ARB_RR_EN → D, D, D, D.
